// File: rtl/inert_pkg.sv
// ============================================================================
// Module : inert_pkg
// Desc   : Shared constants and types for the inertial-sensor SPI responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package inert_pkg;

  // Register map (7-bit SPI addresses)
  localparam logic [6:0] c_ADDR_INT_CTRL = 7'h0D;
  localparam logic [6:0] c_ADDR_WHOAMI   = 7'h0F;
  localparam logic [6:0] c_ADDR_CTRL1    = 7'h10;
  localparam logic [6:0] c_ADDR_CTRL2    = 7'h11;
  localparam logic [6:0] c_ADDR_CTRL5    = 7'h14;
  localparam logic [6:0] c_ADDR_ROLL_L   = 7'h24;
  localparam logic [6:0] c_ADDR_ROLL_H   = 7'h25;
  localparam logic [6:0] c_ADDR_YAW_L    = 7'h26;
  localparam logic [6:0] c_ADDR_YAW_H    = 7'h27;
  localparam logic [6:0] c_ADDR_AY_L     = 7'h2A;
  localparam logic [6:0] c_ADDR_AY_H     = 7'h2B;
  localparam logic [6:0] c_ADDR_AZ_L     = 7'h2C;
  localparam logic [6:0] c_ADDR_AZ_H     = 7'h2D;

  localparam int         c_INT_EN_BIT    = 1;
  localparam logic [4:0] c_CMD_BITS      = 5'd8;
  localparam logic [4:0] c_FRAME_BITS    = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_edge_sync.sv
// ============================================================================
// Module : spi_edge_sync
// Desc   : 2-FF synchronizer followed by registered rise/fall pulse detect.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_edge_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/inert_spi_resp.sv
// ============================================================================
// Module : inert_spi_resp
// Desc   : SPI responder modelling the inertial sensor (config regs, samples,
//          data-ready interrupt) on an oversampled SPI link.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inert_spi_resp
  import inert_pkg::*;
#(
  parameter logic [7:0] WHOAMI = 8'h6A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        new_smpl,
  input  logic [15:0] roll_rt,
  input  logic [15:0] yaw_rt,
  input  logic [15:0] AY,
  input  logic [15:0] AZ,
  output logic [7:0]  int_ctrl,
  output logic [7:0]  ctrl1,
  output logic [7:0]  ctrl2,
  output logic [7:0]  ctrl5,
  output logic        frm_done
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_ss_rise;
  logic        w_ss_fall;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        r_mosi_meta;
  logic        r_mosi_sync;
  logic [4:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift;
  logic        r_rw;
  logic [6:0]  r_addr;
  logic [7:0]  r_tx_shift;
  logic        r_miso;
  logic        r_frm_done;
  logic        r_int_clr;
  logic        r_int;
  logic [7:0]  r_int_ctrl;
  logic [7:0]  r_ctrl1;
  logic [7:0]  r_ctrl2;
  logic [7:0]  r_ctrl5;
  logic [15:0] r_roll;
  logic [15:0] r_yaw;
  logic [15:0] r_ay;
  logic [15:0] r_az;
  logic        w_cmd_done;
  logic        w_frame_end;
  logic        w_cmd_rw;
  logic [6:0]  w_cmd_addr;
  logic [7:0]  w_rd_byte;

  // SS_n sync resets to "selected" so a reset mid-frame cannot fake a new SS_n fall
  spi_edge_sync #(.RST_VAL(1'b0)) u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SS_n),
    .rise (w_ss_rise),
    .fall (w_ss_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SCLK),
    .rise (w_sclk_rise),
    .fall (w_sclk_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= MOSI;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  assign w_cmd_rw    = r_rx_shift[6];
  assign w_cmd_addr  = {r_rx_shift[5:0], r_mosi_sync};
  assign w_cmd_done  = (r_state == ST_CMD) && w_sclk_rise && !w_ss_rise &&
                       (r_bit_cnt == c_CMD_BITS - 5'd1);
  assign w_frame_end = (r_state != ST_IDLE) && w_ss_rise && (r_bit_cnt == c_FRAME_BITS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_ss_fall) w_state_nxt = ST_CMD;
      ST_CMD: begin
        if (w_ss_rise)       w_state_nxt = ST_IDLE;
        else if (w_cmd_done) w_state_nxt = ST_DATA;
      end
      ST_DATA: if (w_ss_rise) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd_byte = 8'h00;
    case (w_cmd_addr)
      c_ADDR_ROLL_L:   w_rd_byte = r_roll[7:0];
      c_ADDR_ROLL_H:   w_rd_byte = r_roll[15:8];
      c_ADDR_YAW_L:    w_rd_byte = r_yaw[7:0];
      c_ADDR_YAW_H:    w_rd_byte = r_yaw[15:8];
      c_ADDR_AY_L:     w_rd_byte = r_ay[7:0];
      c_ADDR_AY_H:     w_rd_byte = r_ay[15:8];
      c_ADDR_AZ_L:     w_rd_byte = r_az[7:0];
      c_ADDR_AZ_H:     w_rd_byte = r_az[15:8];
      c_ADDR_INT_CTRL: w_rd_byte = r_int_ctrl;
      c_ADDR_CTRL1:    w_rd_byte = r_ctrl1;
      c_ADDR_CTRL2:    w_rd_byte = r_ctrl2;
      c_ADDR_CTRL5:    w_rd_byte = r_ctrl5;
      c_ADDR_WHOAMI:   w_rd_byte = WHOAMI;
      default:         w_rd_byte = 8'h00;
    endcase
  end

  // Bit counter saturates at 16 so extra rises neither shift data nor break completeness
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= 5'd0;
      r_rx_shift <= 8'h00;
    end else if ((r_state == ST_IDLE) && w_ss_fall) begin
      r_bit_cnt  <= 5'd0;
      r_rx_shift <= 8'h00;
    end else if ((r_state != ST_IDLE) && w_sclk_rise && (r_bit_cnt != c_FRAME_BITS)) begin
      r_bit_cnt  <= r_bit_cnt + 5'd1;
      r_rx_shift <= {r_rx_shift[6:0], r_mosi_sync};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw       <= 1'b0;
      r_addr     <= 7'h00;
      r_tx_shift <= 8'h00;
      r_miso     <= 1'b0;
    end else begin
      if (w_cmd_done) begin
        r_rw       <= w_cmd_rw;
        r_addr     <= w_cmd_addr;
        r_tx_shift <= w_cmd_rw ? w_rd_byte : 8'h00;
      end else if ((r_state == ST_DATA) && w_sclk_fall) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
      if ((r_state == ST_DATA) && w_sclk_fall) r_miso <= r_tx_shift[7];
      else if (r_state != ST_DATA)             r_miso <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_ctrl <= 8'h00;
      r_ctrl1    <= 8'h00;
      r_ctrl2    <= 8'h00;
      r_ctrl5    <= 8'h00;
    end else if (w_frame_end && !r_rw) begin
      case (r_addr)
        c_ADDR_INT_CTRL: r_int_ctrl <= r_rx_shift;
        c_ADDR_CTRL1:    r_ctrl1    <= r_rx_shift;
        c_ADDR_CTRL2:    r_ctrl2    <= r_rx_shift;
        c_ADDR_CTRL5:    r_ctrl5    <= r_rx_shift;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_roll <= 16'h0000;
      r_yaw  <= 16'h0000;
      r_ay   <= 16'h0000;
      r_az   <= 16'h0000;
    end else if (new_smpl) begin
      r_roll <= roll_rt;
      r_yaw  <= yaw_rt;
      r_ay   <= AY;
      r_az   <= AZ;
    end
  end

  // INT clear lands in the cycle frm_done is high, so a coincident new_smpl wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frm_done <= 1'b0;
      r_int_clr  <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      r_frm_done <= w_frame_end;
      r_int_clr  <= w_frame_end && r_rw && (r_addr == c_ADDR_AZ_H);
      if (new_smpl && r_int_ctrl[c_INT_EN_BIT]) r_int <= 1'b1;
      else if (r_int_clr)                       r_int <= 1'b0;
    end
  end

  assign MISO     = r_miso;
  assign INT      = r_int;
  assign frm_done = r_frm_done;
  assign int_ctrl = r_int_ctrl;
  assign ctrl1    = r_ctrl1;
  assign ctrl2    = r_ctrl2;
  assign ctrl5    = r_ctrl5;

endmodule

`default_nettype wire

// File: tb/tb_inert_spi_resp.sv
// ============================================================================
// Module : tb_inert_spi_resp
// Desc   : Self-checking bench for inert_spi_resp with a register-map model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inert_spi_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        INT;
  logic        new_smpl;
  logic [15:0] roll_rt;
  logic [15:0] yaw_rt;
  logic [15:0] AY;
  logic [15:0] AZ;
  logic [7:0]  int_ctrl;
  logic [7:0]  ctrl1;
  logic [7:0]  ctrl2;
  logic [7:0]  ctrl5;
  logic        frm_done;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  logic [7:0]  m_int_ctrl, m_ctrl1, m_ctrl2, m_ctrl5;
  logic [15:0] m_roll, m_yaw, m_ay, m_az;
  logic        m_int;

  inert_spi_resp #(.WHOAMI(8'h6A)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .INT      (INT),
    .new_smpl (new_smpl),
    .roll_rt  (roll_rt),
    .yaw_rt   (yaw_rt),
    .AY       (AY),
    .AZ       (AZ),
    .int_ctrl (int_ctrl),
    .ctrl1    (ctrl1),
    .ctrl2    (ctrl2),
    .ctrl5    (ctrl5),
    .frm_done (frm_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frm_done === 1'b1) n_done <= n_done + 1;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    case (a)
      7'h24: return m_roll[7:0];
      7'h25: return m_roll[15:8];
      7'h26: return m_yaw[7:0];
      7'h27: return m_yaw[15:8];
      7'h2A: return m_ay[7:0];
      7'h2B: return m_ay[15:8];
      7'h2C: return m_az[7:0];
      7'h2D: return m_az[15:8];
      7'h0D: return m_int_ctrl;
      7'h10: return m_ctrl1;
      7'h11: return m_ctrl2;
      7'h14: return m_ctrl5;
      7'h0F: return 8'h6A;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_int_ctrl = 0; m_ctrl1 = 0; m_ctrl2 = 0; m_ctrl5 = 0;
    m_roll = 0; m_yaw = 0; m_ay = 0; m_az = 0; m_int = 0;
  endtask

  task automatic pulse_smpl(input logic [15:0] r, input logic [15:0] y,
                            input logic [15:0] ay, input logic [15:0] az);
    roll_rt = r; yaw_rt = y; AY = ay; AZ = az;
    new_smpl = 1'b1;
    m_roll = r; m_yaw = y; m_ay = ay; m_az = az;
    if (m_int_ctrl[1]) m_int = 1'b1;
    tick(1);
    new_smpl = 1'b0;
  endtask

  // Drives one frame up to and including the SS_n rise; the read byte the
  // model predicts is taken at the 8th SCLK rise.
  task automatic do_frame(input logic [15:0] cmd, input int rises,
                          output logic [15:0] mw, output logic [7:0] eb);
    mw = 16'h0000;
    eb = 8'h00;
    SS_n = 1'b0;
    tick(6);
    for (int i = 0; i < rises; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      tick(10);
      if (i < 16) mw[15-i] = MISO;
      SCLK = 1'b1;
      if (i == 7) eb = m_read(cmd[14:8]);
      tick(10);
    end
    tick(6);
    SS_n = 1'b1;
    if (rises >= 16) begin
      if (!cmd[15]) begin
        case (cmd[14:8])
          7'h0D: m_int_ctrl = cmd[7:0];
          7'h10: m_ctrl1    = cmd[7:0];
          7'h11: m_ctrl2    = cmd[7:0];
          7'h14: m_ctrl5    = cmd[7:0];
          default: ;
        endcase
      end else if (cmd[14:8] == 7'h2D) begin
        m_int = 1'b0;
      end
    end
  endtask

  task automatic wait_done(output logic found);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick(1);
      if (frm_done === 1'b1) found = 1'b1;
    end
  endtask

  typedef struct {
    logic [15:0] cmd;
    int          rises;
    logic [7:0]  exp_rd;
    int          exp_done;
    logic [7:0]  exp_int_ctrl;
    logic [7:0]  exp_ctrl1;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [15:0] mw;
    logic [7:0]  eb;
    logic        found;
    int          d0;
    logic [6:0]  addrs[15];

    vecs[0] = '{16'h0D02, 16, 8'h00, 1, 8'h02, 8'h00};
    vecs[1] = '{16'h8D00, 16, 8'h02, 1, 8'h02, 8'h00};
    vecs[2] = '{16'h8F00, 16, 8'h6A, 1, 8'h02, 8'h00};
    vecs[3] = '{16'hB000, 16, 8'h00, 1, 8'h02, 8'h00};
    vecs[4] = '{16'h1053, 10, 8'h00, 0, 8'h02, 8'h00};
    vecs[5] = '{16'h1053, 16, 8'h00, 1, 8'h02, 8'h53};
    vecs[6] = '{16'h9000, 16, 8'h53, 1, 8'h02, 8'h53};
    vecs[7] = '{16'h1077, 20, 8'h00, 1, 8'h02, 8'h77};
    vecs[8] = '{16'h4D55, 16, 8'h00, 1, 8'h02, 8'h77};
    vecs[9] = '{16'h8D00,  9, 8'h00, 0, 8'h02, 8'h77};

    addrs = '{7'h0D, 7'h0F, 7'h10, 7'h11, 7'h14, 7'h24, 7'h25, 7'h26,
              7'h27, 7'h2A, 7'h2B, 7'h2C, 7'h2D, 7'h30, 7'h7F};

    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; new_smpl = 1'b0;
    roll_rt = 0; yaw_rt = 0; AY = 0; AZ = 0;
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(3);

    check("reset MISO", 32'(MISO), 32'd0);
    check("reset INT", 32'(INT), 32'd0);
    check("reset frm_done", 32'(frm_done), 32'd0);
    check("reset int_ctrl", 32'(int_ctrl), 32'd0);
    check("reset ctrl1", 32'(ctrl1), 32'd0);
    check("reset ctrl2", 32'(ctrl2), 32'd0);
    check("reset ctrl5", 32'(ctrl5), 32'd0);

    for (int v = 0; v < 10; v++) begin
      d0 = n_done;
      do_frame(vecs[v].cmd, vecs[v].rises, mw, eb);
      tick(12);
      check($sformatf("vec%0d frm_done pulses", v), n_done - d0, vecs[v].exp_done);
      check($sformatf("vec%0d MISO cmd byte", v), 32'(mw[15:8]), 32'd0);
      if (vecs[v].cmd[15] && vecs[v].rises >= 16)
        check($sformatf("vec%0d read byte", v), 32'(mw[7:0]), 32'(vecs[v].exp_rd));
      check($sformatf("vec%0d int_ctrl", v), 32'(int_ctrl), 32'(vecs[v].exp_int_ctrl));
      check($sformatf("vec%0d ctrl1", v), 32'(ctrl1), 32'(vecs[v].exp_ctrl1));
    end

    // INT set by new_smpl, cleared by a complete AZ-high read
    check("int before smpl", 32'(INT), 32'd0);
    pulse_smpl(16'h1234, 16'h5678, 16'h9ABC, 16'hBEEF);
    check("int 1clk after smpl", 32'(INT), 32'd1);
    do_frame(16'hA400, 16, mw, eb);
    tick(12);
    check("read roll L", 32'(mw[7:0]), 32'h34);
    check("int held after roll read", 32'(INT), 32'd1);
    do_frame(16'hAD00, 16, mw, eb);
    wait_done(found);
    check("az read frm_done seen", 32'(found), 32'd1);
    check("int high during frm_done", 32'(INT), 32'd1);
    tick(1);
    check("int cleared after az read", 32'(INT), 32'd0);
    check("read AZ H", 32'(mw[7:0]), 32'hBE);

    // new_smpl coinciding with the clearing frm_done keeps INT set
    pulse_smpl(16'h1111, 16'h0001, 16'h0002, 16'hCAFE);
    do_frame(16'hAD00, 16, mw, eb);
    wait_done(found);
    check("same-cycle frm_done seen", 32'(found), 32'd1);
    pulse_smpl(16'h2222, 16'h0003, 16'h0004, 16'hD00D);
    check("same-cycle set wins", 32'(INT), 32'd1);
    tick(3);
    check("same-cycle int stays", 32'(INT), 32'(m_int));
    check("same-cycle read AZ H", 32'(mw[7:0]), 32'hCA);

    // new_smpl mid-frame must not disturb the byte being shifted out
    fork
      do_frame(16'hA400, 16, mw, eb);
      begin
        tick(250);
        pulse_smpl(16'h33AB, 16'h0005, 16'h0006, 16'h0007);
      end
    join
    tick(12);
    check("mid-frame smpl keeps byte", 32'(mw[7:0]), 32'h22);
    do_frame(16'hA400, 16, mw, eb);
    tick(12);
    check("new roll after frame", 32'(mw[7:0]), 32'hAB);

    // Disabling the interrupt does not drop a pending INT, and blocks new sets
    do_frame(16'h0D00, 16, mw, eb);
    tick(12);
    check("int pending after disable", 32'(INT), 32'd1);
    do_frame(16'hAD00, 16, mw, eb);
    tick(12);
    check("int cleared while disabled", 32'(INT), 32'd0);
    pulse_smpl(16'h4444, 16'h5555, 16'h6666, 16'h7777);
    tick(2);
    check("no int when disabled", 32'(INT), 32'd0);

    // Randomised traffic against the register-map model
    for (int it = 0; it < 40; it++) begin
      int op;
      int ix;
      op = $urandom_range(0, 2);
      ix = $urandom_range(0, 14);
      if (op == 0) begin
        pulse_smpl(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        tick(2);
      end else begin
        do_frame({(op == 2), addrs[ix], 8'($urandom)}, 16, mw, eb);
        tick(12);
        check($sformatf("rand%0d MISO cmd byte", it), 32'(mw[15:8]), 32'd0);
        if (op == 2)
          check($sformatf("rand%0d read addr %0h", it, addrs[ix]), 32'(mw[7:0]), 32'(eb));
      end
      check($sformatf("rand%0d INT", it), 32'(INT), 32'(m_int));
    end
    check("rand int_ctrl", 32'(int_ctrl), 32'(m_int_ctrl));
    check("rand ctrl1", 32'(ctrl1), 32'(m_ctrl1));
    check("rand ctrl2", 32'(ctrl2), 32'(m_ctrl2));
    check("rand ctrl5", 32'(ctrl5), 32'(m_ctrl5));

    // Reset asserted mid-frame
    do_frame(16'h11A5, 16, mw, eb);
    tick(12);
    check("ctrl2 before reset", 32'(ctrl2), 32'hA5);
    SS_n = 1'b0;
    tick(6);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b0; MOSI = mw[0] ^ 1'b0;
      MOSI = (16'h1150 >> (15 - i)) & 16'h1;
      tick(10);
      SCLK = 1'b1;
      tick(10);
    end
    rst = 1'b1;
    #2;
    check("async rst ctrl2", 32'(ctrl2), 32'd0);
    check("async rst MISO", 32'(MISO), 32'd0);
    check("async rst int_ctrl", 32'(int_ctrl), 32'd0);
    check("async rst INT", 32'(INT), 32'd0);
    tick(2);
    rst = 1'b0;
    model_reset();
    d0 = n_done;
    for (int i = 5; i < 16; i++) begin
      SCLK = 1'b0;
      MOSI = (16'h1150 >> (15 - i)) & 16'h1;
      tick(10);
      SCLK = 1'b1;
      tick(10);
    end
    tick(6);
    SS_n = 1'b1;
    tick(12);
    check("post-rst tail no frm_done", n_done - d0, 0);
    check("post-rst tail no write", 32'(ctrl2), 32'd0);
    d0 = n_done;
    do_frame(16'h1150, 16, mw, eb);
    tick(12);
    check("post-rst frame frm_done", n_done - d0, 1);
    check("post-rst frame ctrl2", 32'(ctrl2), 32'h50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
